// File: rtl/demux_1x8_buffer_pkg.sv
// Shared types and defaults for the result demultiplexer (package demux_pkg).
// Channel occupancy is a two-state enum; dado_t is the default word type.
package demux_pkg;

  localparam int LARGURA_PADRAO  = 4;
  localparam int N_SAIDAS_PADRAO = 8;

  typedef enum logic {VAZIO, CHEIO} estado_canal_t;

  typedef logic [LARGURA_PADRAO-1:0] dado_t;

endpackage

// File: rtl/demux_1x8_buffer_canal.sv
// One-entry output buffer: occupancy FSM plus data register for a single channel.
// valida reflects the FSM state directly, so it is a registered output.
module demux_canal
  import demux_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               escrita,
  input  logic [LARGURA-1:0] dado,
  input  logic               aceite,
  output logic [LARGURA-1:0] dado_out,
  output logic               valida
);

  estado_canal_t      estado_q;
  logic [LARGURA-1:0] dado_q;

  // A write while CHEIO only happens together with aceite, so the new word replaces the old.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= VAZIO;
      dado_q   <= '0;
    end else begin
      if (escrita) dado_q <= dado;
      case (estado_q)
        VAZIO:   if (escrita) estado_q <= CHEIO;
        CHEIO:   if (aceite && !escrita) estado_q <= VAZIO;
        default: estado_q <= VAZIO;
      endcase
    end
  end

  assign dado_out = dado_q;
  assign valida   = (estado_q == CHEIO);

endmodule

// File: rtl/demux_1x8_buffer.sv
// Routes one result word into one of N_SAIDAS one-entry buffers by selecao.
// Optional DEMUX_CONTADOR_EN adds a saturating 8-bit count of accepted writes.
//
// Handshake: a word transfers on a cycle where entrada_valida && entrada_pronta;
// entrada_pronta never depends on entrada_valida, and the producer may hold
// entrada_valida high with unchanged entrada/selecao until pronta rises.
module demux_1x8_buffer
  import demux_pkg::*;
#(
  parameter int LARGURA  = LARGURA_PADRAO,
  parameter int N_SAIDAS = N_SAIDAS_PADRAO,
  parameter int SEL_W    = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [LARGURA-1:0]                entrada,
  input  logic [SEL_W-1:0]                  selecao,
  input  logic                              entrada_valida,
  output logic                              entrada_pronta,
  output logic [N_SAIDAS-1:0][LARGURA-1:0]  saida,
  output logic [N_SAIDAS-1:0]               saida_valida,
  input  logic [N_SAIDAS-1:0]               aceite,
  output logic                              erro_sel,
  output logic [7:0]                        contador
);

  logic                sel_hit;
  logic                cheio_sel;
  logic                aceite_sel;
  logic                transfer;
  logic [N_SAIDAS-1:0] escrita;
  logic                erro_q;

  always_comb begin
    sel_hit    = 1'b0;
    cheio_sel  = 1'b0;
    aceite_sel = 1'b0;
    for (int k = 0; k < N_SAIDAS; k++) begin
      if (selecao == SEL_W'(k)) begin
        sel_hit    = 1'b1;
        cheio_sel  = saida_valida[k];
        aceite_sel = aceite[k];
      end
    end
  end

  assign entrada_pronta = !sel_hit || !cheio_sel || aceite_sel;
  assign transfer       = entrada_valida && entrada_pronta;

  always_comb begin
    escrita = '0;
    for (int k = 0; k < N_SAIDAS; k++) begin
      escrita[k] = transfer && (selecao == SEL_W'(k));
    end
  end

  for (genvar g = 0; g < N_SAIDAS; g++) begin : g_canal
    demux_canal #(.LARGURA(LARGURA)) u_canal (
      .clk      (clk),
      .reset    (reset),
      .escrita  (escrita[g]),
      .dado     (entrada),
      .aceite   (aceite[g]),
      .dado_out (saida[g]),
      .valida   (saida_valida[g])
    );
  end

  // Out-of-range selecao is still "accepted" so the producer never stalls on it.
  always_ff @(posedge clk) begin
    if (reset) erro_q <= 1'b0;
    else       erro_q <= transfer && !sel_hit;
  end
  assign erro_sel = erro_q;

`ifdef DEMUX_CONTADOR_EN
  logic [7:0] contador_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      contador_q <= 8'h00;
    end else if (transfer && sel_hit && (contador_q != 8'hFF)) begin
      contador_q <= contador_q + 8'd1;
    end
  end
  assign contador = contador_q;
`else
  assign contador = 8'h00;
`endif

endmodule
